// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes and funct field encodings
// Used by alu_op_decode, alu_control_unit and the ALU itself.
package alu_pkg;
    typedef logic [2:0] alu_opcode_t;
    localparam alu_opcode_t ALU_NOP   = 3'b000;
    localparam alu_opcode_t ALU_LOAD  = 3'b001;
    localparam alu_opcode_t ALU_STORE = 3'b010;
    localparam alu_opcode_t ALU_ADD   = 3'b011;
    localparam alu_opcode_t ALU_NOT   = 3'b100;
    localparam logic [2:0] FUNCT_NOP   = 3'b000;
    localparam logic [2:0] FUNCT_LOAD  = 3'b001;
    localparam logic [2:0] FUNCT_STORE = 3'b010;
    localparam logic [2:0] FUNCT_ADD   = 3'b011;
    localparam logic [2:0] FUNCT_NOT   = 3'b100;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational alu_op/funct to ALU operation decode
// Ports: alu_op (1 = use funct), funct [2:0]; operation [2:0], illegal (reserved funct with alu_op=1).
module alu_op_decode
    import alu_pkg::*;
(
    input  logic        alu_op,
    input  logic [2:0]  funct,
    output alu_opcode_t operation,
    output logic        illegal
);
    always_comb begin
        operation = ALU_NOP;
        illegal   = 1'b0;
        if (alu_op) begin
            case (funct)
                FUNCT_NOP:   operation = ALU_NOP;
                FUNCT_LOAD:  operation = ALU_LOAD;
                FUNCT_STORE: operation = ALU_STORE;
                FUNCT_ADD:   operation = ALU_ADD;
                FUNCT_NOT:   operation = ALU_NOT;
                default:     illegal   = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: registered ALU operation decode, the operation slice of ID/EX
// Ports: clk, rst (sync, active high), alu_op, funct [2:0], stall (hold), flush (bubble);
//        operation [2:0] and illegal are registered outputs. Priority: rst > flush > stall > load.
module alu_control_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_op,
    input  logic [2:0]  funct,
    input  logic        stall,
    input  logic        flush,
    output alu_opcode_t operation,
    output logic        illegal
);
    alu_opcode_t next_operation;
    logic        next_illegal;

    alu_op_decode u_decode (
        .alu_op    (alu_op),
        .funct     (funct),
        .operation (next_operation),
        .illegal   (next_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            operation <= ALU_NOP;
            illegal   <= 1'b0;
        end else if (!stall) begin
            operation <= next_operation;
            illegal   <= next_illegal;
        end
    end
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed table-driven bench for alu_control_unit
module tb_alu_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alu_op = 1'b0;
    logic [2:0] funct = 3'b000;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] operation;
    logic       illegal;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic       alu_op;
        logic [2:0] funct;
        logic       stall;
        logic       flush;
        logic [2:0] exp_op;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[$];

    alu_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .alu_op    (alu_op),
        .funct     (funct),
        .stall     (stall),
        .flush     (flush),
        .operation (operation),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic a, input logic [2:0] f, input logic s, input logic fl);
        @(negedge clk);
        rst = r;
        alu_op = a;
        funct = f;
        stall = s;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] eop, input logic eill);
        checks++;
        if (operation !== eop || illegal !== eill) begin
            failures++;
            $display("FAIL %s: operation=%b illegal=%b, required operation=%b illegal=%b",
                     name, operation, illegal, eop, eill);
        end
    endtask

    initial begin
        // reset held two cycles with a live ADD on the inputs
        vecs.push_back('{1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 3'b000, 1'b0});
        // legal sweep
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 3'b011, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0});
        // alu_op=0 ignores funct entirely
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b0, 1'b0, 3'(i), 1'b0, 1'b0, 3'b000, 1'b0});
        // reserved funct codes
        vecs.push_back('{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 3'b011, 1'b0});
        // illegal flag is held by stall and cleared by flush
        vecs.push_back('{1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 3'b000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 3'b000, 1'b0});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].alu_op, vecs[i].funct, vecs[i].stall, vecs[i].flush);
            check($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_ill);
        end

        // stall for three cycles holds ADD, release loads NOT
        step(1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
        check("load_add", 3'b011, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
            check($sformatf("stall_hold%0d", k), 3'b011, 1'b0);
        end
        step(1'b0, 1'b1, 3'b100, 1'b0, 1'b0);
        check("stall_release", 3'b100, 1'b0);

        // flush beats stall
        step(1'b0, 1'b1, 3'b100, 1'b1, 1'b1);
        check("flush_over_stall", 3'b000, 1'b0);

        // reset during stall clears outputs
        step(1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        check("load_store", 3'b010, 1'b0);
        step(1'b0, 1'b1, 3'b011, 1'b1, 1'b0);
        check("stall_store", 3'b010, 1'b0);
        step(1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
        check("rst_in_stall", 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0);
        check("post_rst_illegal", 3'b000, 1'b1);
        step(1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
        check("rst_all", 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_control_unit.md
# alu_control_unit

Decodes the ALU-operation class (`alu_op`) and the instruction function field (`funct`) into the 3-bit ALU operation code consumed by the execute stage of the pipelined processor. It sits at the decode/execute boundary. Its output is registered, so it also acts as the operation slice of the ID/EX pipeline register, with stall (hold) and flush (bubble) control. Reserved function codes are flagged as illegal and are never passed to the ALU.

## Interface
Parameters: none. All widths are fixed: `funct` is 3 bits and `operation` is 3 bits.

Ports:
- `clk`  in  1  Single clock; all state updates on its rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `alu_op`  in  1  1 = instruction uses the ALU per `funct`; 0 = no ALU operation (NOP).
- `funct`  in  3  Instruction function field.
- `stall`  in  1  1 = hold registered outputs unchanged.
- `flush`  in  1  1 = load a bubble (NOP) into the registered outputs.
- `operation`  out  3  Registered ALU operation code.
- `illegal`  out  1  Registered flag: 1 = reserved `funct` was decoded with `alu_op`=1.

## Operation
Operation codes:
- `000` NOP
- `001` LOAD
- `010` STORE
- `011` ADD
- `100` NOT
- `101`–`111` are not produced.

Combinational decode (next value):
- `alu_op`=0: next `operation`=`000`, next `illegal`=0, regardless of `funct`.
- `alu_op`=1, `funct`=`000`: `000`, illegal 0.
- `alu_op`=1, `funct`=`001`: `001` LOAD.
- `alu_op`=1, `funct`=`010`: `010` STORE.
- `alu_op`=1, `funct`=`011`: `011` ADD.
- `alu_op`=1, `funct`=`100`: `100` NOT.
- `alu_op`=1, `funct`=`101`/`110`/`111` (reserved): `operation`=`000`, `illegal`=1.
- X/Z on inputs does not need defined handling. The decode is a full case with NOP as the default.

Register update priority at each rising `clk` (highest first):
1. `rst`=1: `operation`=`000`, `illegal`=0.
2. `flush`=1: `operation`=`000`, `illegal`=0. Flush wins over stall.
3. `stall`=1: both outputs hold their previous values.
4. Otherwise: load the decoded next values.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- Reset value: `operation`=`000`, `illegal`=0.
  - Reset is synchronous. Asserting `rst` mid-stream clears the outputs at the next edge, whatever `stall` or `flush` are doing.
- `stall` held for k cycles holds the outputs for k cycles. On deassertion, the next edge loads the current inputs. Inputs presented during the stall are not buffered.
- `flush` and `stall` asserted together produce NOP at that edge.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `alu_pkg`:
  - 3-bit operation-code typedef.
  - Named constants `ALU_NOP`, `ALU_LOAD`, `ALU_STORE`, `ALU_ADD`, `ALU_NOT`.
  - Named `funct` constants for the same five codes.
  - The package is also imported by the ALU itself.
- One natural sub-module: `alu_op_decode`, the purely combinational `alu_op`/`funct` to {`operation`, `illegal`} decode.
- The top level adds the priority register (reset > flush > stall > load).

## Test plan
1. Reset: hold `rst`=1 for 2 cycles with `alu_op`=1 and `funct`=`011`. Required: `operation`=`000`, `illegal`=0.
2. Sweep with `alu_op`=1, one value per cycle: `funct`=`001`, `010`, `011`, `100`. Required, one cycle later each: `operation`=`001`, `010`, `011`, `100`, with `illegal`=0.
3. Set `alu_op`=0 and sweep all 8 `funct` values (including `101`). Required: `operation`=`000` and `illegal`=0 throughout.
4. Set `alu_op`=1 and apply `funct`=`101`, `110`, `111`. Required: `operation`=`000` and `illegal`=1 each time. Then apply `funct`=`011`. Required: `illegal` returns to 0.
5. Load ADD (`011`), then raise `stall` for 3 cycles while `funct`=`100`. Required: `operation` stays `011` for those 3 cycles and becomes `100` one cycle after `stall` drops.
6. With `operation`=`100`, assert `flush`=1 and `stall`=1 together. Required: `operation`=`000` next cycle. Then assert `rst` during a stall. Required: outputs clear at the next edge.
